// File: rtl/fpdiv_pkg.sv
// Shared types and constants for the FPU divide post-processing path.
package fpdiv_pkg;

  typedef enum logic [2:0] {
    RM_RNE = 3'd0,
    RM_RTZ = 3'd1,
    RM_RDN = 3'd2,
    RM_RUP = 3'd3,
    RM_RMM = 3'd4
  } rm_t;

  localparam int EW_STD = 8;
  localparam int FW_STD = 23;

  function automatic int bias_of(input int ew);
    return (1 << (ew - 1)) - 1;
  endfunction

  function automatic int exp_max_of(input int ew);
    return (1 << ew) - 1;
  endfunction

  localparam int BIAS    = bias_of(EW_STD);
  localparam int EXP_MAX = exp_max_of(EW_STD);

  // Canonical quiet NaN: sign 0, exponent all ones, fraction MSB set.
  function automatic logic [63:0] qnan(input int ew, input int fw);
    logic [63:0] r;
    r = '0;
    for (int i = 0; i < ew; i++) r[fw + i] = 1'b1;
    r[fw - 1] = 1'b1;
    return r;
  endfunction

endpackage

// File: rtl/fpdiv_round.sv
// Round-increment decision from rounding mode, sign, lsb, guard and sticky.
module fpdiv_round
  import fpdiv_pkg::*;
(
  input  logic [2:0] rm,
  input  logic       sgn,
  input  logic       lsb,
  input  logic       guard,
  input  logic       sticky,
  output logic       inc
);

  rm_t rm_e;
  assign rm_e = rm_t'(rm);

  always_comb begin
    inc = 1'b0;
    case (rm_e)
      RM_RTZ:  inc = 1'b0;
      RM_RDN:  inc = (guard | sticky) & sgn;
      RM_RUP:  inc = (guard | sticky) & ~sgn;
      RM_RMM:  inc = guard;
      default: inc = guard & (sticky | lsb);
    endcase
  end

endmodule

// File: rtl/fpdiv_post.sv
// Divide post-processing: normalize, round and pack in a 3-stage stall pipeline.
// Define FPDIV_POST_DENORM_EN for gradual underflow; otherwise tiny results flush to signed zero.
module fpdiv_post
  import fpdiv_pkg::*;
#(
  parameter int EW    = 8,
  parameter int FW    = 23,
  parameter int QW    = 48,
  parameter int QFRAC = 46
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             i_valid,
  output logic             i_ready,
  input  logic             i_sgn,
  input  logic [EW-1:0]    i_exp_a,
  input  logic [EW-1:0]    i_exp_b,
  input  logic [QW-1:0]    i_q,
  input  logic [7:0]       i_lzcnt,
  input  logic             i_nan,
  input  logic             i_inf,
  input  logic             i_zero,
  input  logic [2:0]       i_rm,
  output logic             o_valid,
  input  logic             o_ready,
  output logic [EW+FW:0]   o_res,
  output logic             o_of,
  output logic             o_uf,
  output logic             o_inx
);

  localparam int EXW    = EW + 3;
  localparam int RW     = 1 + EW + FW;
  localparam int SW     = FW + 2;
  localparam int E_BIAS = (EW == EW_STD) ? BIAS : bias_of(EW);
  localparam int E_MAX  = (EW == EW_STD) ? EXP_MAX : exp_max_of(EW);
  localparam logic [RW-1:0] QNAN_RES = RW'(qnan(EW, FW));

  logic advance;
  assign advance = !o_valid || o_ready;
  assign i_ready = advance;

  // ---------------- S1: normalize ----------------
  logic signed [EXW-1:0] e_raw, s1_e_next;
  logic [QW-1:0]         m_norm, s1_m_next;
  logic                  tiny, s1_sticky_next;

  assign e_raw  = EXW'(i_exp_a) - EXW'(i_exp_b) + EXW'(E_BIAS + QW - 1 - QFRAC) - EXW'(i_lzcnt);
  assign m_norm = i_q << i_lzcnt;
  assign tiny   = e_raw[EXW-1] || (e_raw == '0);

`ifdef FPDIV_POST_DENORM_EN
  localparam int SHW = $clog2(FW + 4);
  logic [EXW-1:0] sh_full;
  logic [SHW-1:0] sh;

  // Beyond FW+3 every bit already lands below the guard position.
  assign sh_full = EXW'(1) - e_raw;
  assign sh = (sh_full > EXW'(FW + 3)) ? SHW'(FW + 3) : sh_full[SHW-1:0];

  always_comb begin
    s1_m_next      = m_norm;
    s1_e_next      = e_raw;
    s1_sticky_next = 1'b0;
    if (tiny) begin
      s1_m_next      = m_norm >> sh;
      s1_e_next      = '0;
      s1_sticky_next = |(m_norm & ~({QW{1'b1}} << sh));
    end
  end
`else
  assign s1_m_next      = m_norm;
  assign s1_e_next      = e_raw;
  assign s1_sticky_next = 1'b0;
`endif

  logic                  s1_valid_reg, s1_sgn_reg, s1_sticky_reg, s1_tiny_reg;
  logic                  s1_nan_reg, s1_inf_reg, s1_zero_reg;
  logic signed [EXW-1:0] s1_e_reg;
  logic [QW-1:0]         s1_m_reg;
  logic [2:0]            s1_rm_reg;

  // ---------------- S2: round ----------------
  logic [FW:0]           mant;
  logic                  guard, sticky, inc;
  logic [SW-1:0]         sum;
  logic signed [EXW-1:0] s2_e_next;
  logic [FW-1:0]         s2_frac_next;

  assign mant   = s1_m_reg[QW-1 -: FW+1];
  assign guard  = s1_m_reg[QW-FW-2];
  assign sticky = (|s1_m_reg[QW-FW-3:0]) | s1_sticky_reg;

  fpdiv_round u_round (
    .rm     (s1_rm_reg),
    .sgn    (s1_sgn_reg),
    .lsb    (mant[0]),
    .guard  (guard),
    .sticky (sticky),
    .inc    (inc)
  );

  assign sum = {1'b0, mant} + SW'(inc);

  // A denormal that rounds up into the hidden bit becomes the smallest normal.
  always_comb begin
    s2_frac_next = sum[FW-1:0];
    s2_e_next    = s1_e_reg;
    if (sum[FW+1]) begin
      s2_frac_next = sum[FW:1];
      s2_e_next    = s1_e_reg + EXW'(1);
    end else if (s1_e_reg == '0 && sum[FW]) begin
      s2_e_next = EXW'(1);
    end
  end

  logic                  s2_valid_reg, s2_sgn_reg, s2_inx_reg, s2_tiny_reg;
  logic                  s2_nan_reg, s2_inf_reg, s2_zero_reg;
  logic signed [EXW-1:0] s2_e_reg;
  logic [FW-1:0]         s2_frac_reg;
  logic [2:0]            s2_rm_reg;

  // ---------------- S3: pack and exceptions ----------------
  logic [RW-1:0] res_next;
  logic          of_next, uf_next, inx_next, of_inf;

  always_comb begin
    of_inf = 1'b1;
    case (rm_t'(s2_rm_reg))
      RM_RTZ:  of_inf = 1'b0;
      RM_RUP:  of_inf = ~s2_sgn_reg;
      RM_RDN:  of_inf = s2_sgn_reg;
      default: of_inf = 1'b1;
    endcase
  end

  always_comb begin
    res_next = {s2_sgn_reg, s2_e_reg[EW-1:0], s2_frac_reg};
    of_next  = 1'b0;
    uf_next  = 1'b0;
    inx_next = s2_inx_reg;
    if (s2_nan_reg) begin
      res_next = QNAN_RES;
      inx_next = 1'b0;
    end else if (s2_inf_reg) begin
      res_next = {s2_sgn_reg, {EW{1'b1}}, {FW{1'b0}}};
      inx_next = 1'b0;
    end else if (s2_zero_reg) begin
      res_next = {s2_sgn_reg, {(RW-1){1'b0}}};
      inx_next = 1'b0;
`ifndef FPDIV_POST_DENORM_EN
    end else if (s2_tiny_reg) begin
      res_next = {s2_sgn_reg, {(RW-1){1'b0}}};
      uf_next  = 1'b1;
      inx_next = 1'b1;
`endif
    end else if (s2_e_reg >= EXW'(E_MAX)) begin
      of_next  = 1'b1;
      inx_next = 1'b1;
      res_next = of_inf ? {s2_sgn_reg, {EW{1'b1}}, {FW{1'b0}}}
                        : {s2_sgn_reg, {(EW-1){1'b1}}, 1'b0, {FW{1'b1}}};
    end else begin
      uf_next = s2_tiny_reg & s2_inx_reg;
    end
  end

  // ---------------- pipeline registers ----------------
  always_ff @(posedge clk) begin
    if (rst) begin
      s1_valid_reg <= 1'b0;
      s2_valid_reg <= 1'b0;
      o_valid      <= 1'b0;
      o_res        <= '0;
      o_of         <= 1'b0;
      o_uf         <= 1'b0;
      o_inx        <= 1'b0;
    end else if (advance) begin
      s1_valid_reg <= i_valid;
      s2_valid_reg <= s1_valid_reg;
      o_valid      <= s2_valid_reg;
      if (s2_valid_reg) begin
        o_res <= res_next;
        o_of  <= of_next;
        o_uf  <= uf_next;
        o_inx <= inx_next;
      end
    end
  end

  always_ff @(posedge clk) begin
    if (advance) begin
      s1_sgn_reg    <= i_sgn;
      s1_e_reg      <= s1_e_next;
      s1_m_reg      <= s1_m_next;
      s1_sticky_reg <= s1_sticky_next;
      s1_tiny_reg   <= tiny;
      s1_nan_reg    <= i_nan;
      s1_inf_reg    <= i_inf;
      s1_zero_reg   <= i_zero | (i_q == '0);
      s1_rm_reg     <= i_rm;

      s2_sgn_reg    <= s1_sgn_reg;
      s2_e_reg      <= s2_e_next;
      s2_frac_reg   <= s2_frac_next;
      s2_inx_reg    <= guard | sticky;
      s2_tiny_reg   <= s1_tiny_reg;
      s2_nan_reg    <= s1_nan_reg;
      s2_inf_reg    <= s1_inf_reg;
      s2_zero_reg   <= s1_zero_reg;
      s2_rm_reg     <= s1_rm_reg;
    end
  end

endmodule

// File: tb/tb_fpdiv_post.sv
// Scoreboard bench for fpdiv_post: directed vectors, expected results queued at accept time.
module tb_fpdiv_post;
  import fpdiv_pkg::*;

  logic        clk = 1'b0;
  logic        rst;
  logic        i_valid, i_ready, i_sgn, i_nan, i_inf, i_zero;
  logic [7:0]  i_exp_a, i_exp_b, i_lzcnt;
  logic [47:0] i_q;
  logic [2:0]  i_rm;
  logic        o_valid, o_ready, o_of, o_uf, o_inx;
  logic [31:0] o_res;

  typedef struct packed {
    logic [31:0] res;
    logic        of;
    logic        uf;
    logic        inx;
  } exp_t;

  exp_t exp_q[$];
  int   checks = 0;
  int   errors = 0;
  int   beat_no = 0;

  localparam logic [47:0] Q15  = 48'h600000000000;  // 1.5
  localparam logic [47:0] Q10  = 48'h400000000000;  // 1.0
  localparam logic [47:0] Q23  = 48'h2AAAAAAAAAAA;  // 2/3 (1.0 / 1.5 mantissas)
  localparam logic [47:0] QTOP = 48'h7FFFFFC00000;  // all-ones mantissa, guard set

`ifdef FPDIV_POST_DENORM_EN
  localparam exp_t UF_EXACT = {32'h00200000, 3'b000};
  localparam exp_t UF_INX   = {32'h00000002, 3'b011};
`else
  localparam exp_t UF_EXACT = {32'h00000000, 3'b011};
  localparam exp_t UF_INX   = {32'h00000000, 3'b011};
`endif

  fpdiv_post dut (
    .clk     (clk),
    .rst     (rst),
    .i_valid (i_valid),
    .i_ready (i_ready),
    .i_sgn   (i_sgn),
    .i_exp_a (i_exp_a),
    .i_exp_b (i_exp_b),
    .i_q     (i_q),
    .i_lzcnt (i_lzcnt),
    .i_nan   (i_nan),
    .i_inf   (i_inf),
    .i_zero  (i_zero),
    .i_rm    (i_rm),
    .o_valid (o_valid),
    .o_ready (o_ready),
    .o_res   (o_res),
    .o_of    (o_of),
    .o_uf    (o_uf),
    .o_inx   (o_inx)
  );

  always #5 clk = ~clk;

  // Monitor: a beat transfers at the next posedge when o_valid && o_ready here.
  always @(negedge clk) begin
    if (!rst && o_valid && o_ready) begin
      exp_t e;
      checks++;
      if (exp_q.size() == 0) begin
        errors++;
        $display("FAIL unexpected_beat: got res=%h with no beat outstanding", o_res);
      end else begin
        e = exp_q.pop_front();
        if ({o_res, o_of, o_uf, o_inx} !== e) begin
          errors++;
          $display("FAIL beat %0d: got res=%h of=%b uf=%b inx=%b, required res=%h of=%b uf=%b inx=%b",
                   beat_no, o_res, o_of, o_uf, o_inx, e.res, e.of, e.uf, e.inx);
        end else begin
          $display("beat %0d ok: res=%h of=%b uf=%b inx=%b", beat_no, o_res, o_of, o_uf, o_inx);
        end
      end
      beat_no++;
    end
  end

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] req);
    checks++;
    if (act !== req) begin
      errors++;
      $display("FAIL %s: got %h, required %h", name, act, req);
    end
  endtask

  task automatic step;
    @(posedge clk);
    #1;
  endtask

  // Called one time unit after a posedge; returns one time unit after the accepting edge.
  task automatic send(input logic sgn, input logic [7:0] ea, input logic [7:0] eb,
                      input logic [47:0] q, input logic [7:0] lz, input logic [2:0] rm,
                      input logic [2:0] cls, input exp_t e);
    int n;
    n = 0;
    i_sgn = sgn; i_exp_a = ea; i_exp_b = eb; i_q = q; i_lzcnt = lz; i_rm = rm;
    {i_nan, i_inf, i_zero} = cls;
    i_valid = 1'b1;
    while (1) begin
      @(negedge clk);
      if (i_ready) break;
      n++;
      if (n == 100) begin
        checks++;
        errors++;
        $display("FAIL accept_timeout: i_ready stayed 0 for 100 cycles, required 1");
        i_valid = 1'b0;
        return;
      end
      step();
    end
    exp_q.push_back(e);
    step();
    i_valid = 1'b0;
  endtask

  task automatic drain(input string name);
    int n;
    n = 0;
    while (exp_q.size() != 0 && n < 50) begin
      step();
      n++;
    end
    checks++;
    if (exp_q.size() != 0) begin
      errors++;
      $display("FAIL %s: %0d beats still pending, required 0", name, exp_q.size());
    end
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached before completion");
    $fatal(1, "watchdog expired");
  end

  initial begin
    rst = 1'b1; i_valid = 1'b0; o_ready = 1'b1;
    i_sgn = 1'b0; i_exp_a = '0; i_exp_b = '0; i_q = '0; i_lzcnt = '0;
    i_nan = 1'b0; i_inf = 1'b0; i_zero = 1'b0; i_rm = '0;
    repeat (3) @(posedge clk);
    #1 rst = 1'b0;

    @(negedge clk);
    chk("reset_o_valid", 32'(o_valid), 32'd0);
    chk("reset_o_res", o_res, 32'd0);
    chk("reset_flags", 32'({o_of, o_uf, o_inx}), 32'd0);
    chk("reset_i_ready", 32'(i_ready), 32'd1);
    step();

    // Latency: o_valid rises on the third edge after acceptance.
    send(1'b0, 8'd127, 8'd127, Q15, 8'd1, RM_RNE, 3'b000, {32'h3FC00000, 3'b000});
    @(negedge clk); chk("latency_c1", 32'(o_valid), 32'd0);
    @(negedge clk); chk("latency_c2", 32'(o_valid), 32'd0);
    @(negedge clk); chk("latency_c3", 32'(o_valid), 32'd1);
    step();

    // Rounding modes on 1.0/3.0 (mantissa quotient 2/3, exponent 127-128).
    send(1'b0, 8'd127, 8'd128, Q23, 8'd2, RM_RNE, 3'b000, {32'h3EAAAAAB, 3'b001});
    send(1'b0, 8'd127, 8'd128, Q23, 8'd2, RM_RTZ, 3'b000, {32'h3EAAAAAA, 3'b001});
    send(1'b0, 8'd127, 8'd128, Q23, 8'd2, RM_RUP, 3'b000, {32'h3EAAAAAB, 3'b001});
    send(1'b0, 8'd127, 8'd128, Q23, 8'd2, RM_RDN, 3'b000, {32'h3EAAAAAA, 3'b001});
    send(1'b1, 8'd127, 8'd128, Q23, 8'd2, RM_RDN, 3'b000, {32'hBEAAAAAB, 3'b001});
    send(1'b0, 8'd127, 8'd128, Q23, 8'd2, RM_RMM, 3'b000, {32'h3EAAAAAB, 3'b001});
    send(1'b0, 8'd127, 8'd128, Q23, 8'd2, 3'd7,   3'b000, {32'h3EAAAAAB, 3'b001});

    // Mantissa carry-out on rounding.
    send(1'b0, 8'd127, 8'd127, QTOP, 8'd1, RM_RNE, 3'b000, {32'h40000000, 3'b001});
    send(1'b0, 8'd127, 8'd127, QTOP, 8'd1, RM_RTZ, 3'b000, {32'h3FFFFFFF, 3'b001});

    // Overflow boundary and directed overflow results.
    send(1'b0, 8'd254, 8'd127, Q15, 8'd1, RM_RNE, 3'b000, {32'h7F400000, 3'b000});
    send(1'b0, 8'd254, 8'd126, Q15, 8'd1, RM_RNE, 3'b000, {32'h7F800000, 3'b101});
    send(1'b0, 8'd254, 8'd1,   Q15, 8'd1, RM_RNE, 3'b000, {32'h7F800000, 3'b101});
    send(1'b0, 8'd254, 8'd1,   Q15, 8'd1, RM_RTZ, 3'b000, {32'h7F7FFFFF, 3'b101});
    send(1'b1, 8'd254, 8'd1,   Q15, 8'd1, RM_RDN, 3'b000, {32'hFF800000, 3'b101});
    send(1'b1, 8'd254, 8'd1,   Q15, 8'd1, RM_RUP, 3'b000, {32'hFF7FFFFF, 3'b101});
    send(1'b0, 8'd254, 8'd127, QTOP, 8'd1, RM_RNE, 3'b000, {32'h7F800000, 3'b101});

    // Underflow: exact 2^-128 and an inexact deep denormal.
    send(1'b0, 8'd1, 8'd129, Q10, 8'd1, RM_RNE, 3'b000, UF_EXACT);
    send(1'b0, 8'd1, 8'd150, Q15, 8'd1, RM_RNE, 3'b000, UF_INX);

    // Special classes and zero quotient.
    send(1'b0, 8'd127, 8'd127, Q15, 8'd1, RM_RNE, 3'b100, {32'h7FC00000, 3'b000});
    send(1'b1, 8'd127, 8'd127, Q15, 8'd1, RM_RNE, 3'b100, {32'h7FC00000, 3'b000});
    send(1'b1, 8'd127, 8'd127, Q15, 8'd1, RM_RNE, 3'b010, {32'hFF800000, 3'b000});
    send(1'b0, 8'd127, 8'd127, Q15, 8'd1, RM_RNE, 3'b001, {32'h00000000, 3'b000});
    send(1'b1, 8'd127, 8'd127, 48'd0, 8'd48, RM_RNE, 3'b000, {32'h80000000, 3'b000});
    drain("drain_directed");

    // Backpressure: six back-to-back beats against five stalled cycles.
    fork
      begin
        for (int k = 0; k < 6; k++)
          send(1'b0, 8'(120 + k), 8'd127, Q15, 8'd1, RM_RNE, 3'b000,
               {1'b0, 8'(120 + k), 23'h400000, 3'b000});
      end
      begin
        o_ready = 1'b0;
        repeat (3) @(posedge clk);
        @(negedge clk);
        chk("stall_i_ready", 32'(i_ready), 32'd0);
        chk("stall_o_valid", 32'(o_valid), 32'd1);
        chk("stall_held_beats", 32'(exp_q.size()), 32'd3);
        @(posedge clk);
        @(posedge clk);
        #1 o_ready = 1'b1;
      end
    join
    drain("drain_backpressure");

    // Reset with two beats in flight discards them.
    send(1'b0, 8'd100, 8'd127, Q15, 8'd1, RM_RNE, 3'b000, {32'h32400000, 3'b000});
    send(1'b0, 8'd101, 8'd127, Q15, 8'd1, RM_RNE, 3'b000, {32'h32C00000, 3'b000});
    rst = 1'b1;
    exp_q.delete();
    step();
    chk("rst_mid_o_valid", 32'(o_valid), 32'd0);
    rst = 1'b0;
    for (int k = 0; k < 3; k++) begin
      @(negedge clk);
      chk("rst_flushed", 32'(o_valid), 32'd0);
    end
    step();
    send(1'b0, 8'd127, 8'd127, Q15, 8'd1, RM_RNE, 3'b000, {32'h3FC00000, 3'b000});
    drain("drain_after_reset");

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
